eb_rr_arb: RTL and testbench
============================

// Module: eb_rr_arb
// PURPOSE
// - Shares one elastic-buffer output stream among NUM_PORTS valid/ready requesters.
// - Round-robin arbitration with packet lock: a granted port keeps the stream until its t_last beat.
// - Output is a registered 2-entry elastic stage: full throughput, no combinational path i_ready->t_ready.
// - Sits ahead of eb1 chains wherever several producers feed one consumer.
// PARAMETERS
// - NUM_PORTS  4   number of requesters (>=1)
// - DWIDTH     32  data width per beat
// - IDW        $clog2(NUM_PORTS), min 1  width of the i_id source tag
// PORTS
// - clk      in   1                  single clock, all flops on posedge
// - rst      in   1                  asynchronous, active-high reset
// - t_data   in   NUM_PORTS*DWIDTH   requester data, port p at [p*DWIDTH +: DWIDTH]
// - t_last   in   NUM_PORTS          last beat of requester packet
// - t_valid  in   NUM_PORTS          requester valid
// - t_ready  out  NUM_PORTS          requester ready, at most one bit set per cycle
// - i_data   out  DWIDTH             output data
// - i_last   out  1                  output last
// - i_id     out  IDW                source port of the output beat
// - i_valid  out  1                  output valid
// - i_ready  in   1                  downstream ready
// BEHAVIOUR
// - Reset: i_valid=0, i_data=0, i_last=0, i_id=0, t_ready=0, state=IDLE, ptr=NUM_PORTS-1 (port 0 wins first).
// - Beat transfer on any side: valid & ready in the same cycle; valid never depends on ready.
// - buf_rdy = (count<2), registered; t_ready[p] = buf_rdy & grant[p]; zero ports ready when buffer full.
// - Grant (combinational from regs + t_valid):
//   IDLE: first p with t_valid[p] searching ptr+1, ptr+2, ... wrapping mod NUM_PORTS; none -> grant=0.
//   LOCKED: grant = onehot(lock_id) regardless of other valids; t_valid of lock_id merely gates transfer.
// - FSM: IDLE --accept beat with t_last=0--> LOCKED(lock_id=granted port).
//   IDLE --accept beat with t_last=1--> IDLE (single-beat packet). LOCKED --accept t_last=1--> IDLE.
//   LOCKED with lock port idle: stay LOCKED, no timeout.
// - ptr <= granted port on every accepted t_last beat; ptr unchanged otherwise.
// - Output buffer: 2 entries {data,last,id}, FIFO order; accepted beat visible on i_valid next cycle.
//   count 0: push -> 1. count 1: push&pop -> 1; push only -> 2; pop only -> 0. count 2: pop only -> 1.
//   i_valid = (count!=0); i_data/i_last/i_id from head entry, stable while i_valid & ~i_ready.
// - Sustained 1 beat/cycle when i_ready held high; i_ready low 1 cycle costs no bubble.
// - Reset mid-packet: lock released, buffer flushed, any in-flight beats dropped.
// - NUM_PORTS=1: grant always port 0, i_id=0; FSM still tracks t_last (no functional effect).
// STRUCTURE
// - Package eb_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e; function clog2_min1.
// - Sub-module eb2 (2-entry elastic buffer, params DWIDTH; ports clk, rst, t_*/i_* valid/ready/data);
//   instantiated once with DWIDTH+1+IDW payload {last,id,data}.
// - Top holds FSM, ptr, lock_id and the round-robin priority search (loop over 2*NUM_PORTS).
// TESTING
// - Reset: rst=1 with all t_valid=1 -> t_ready=0, i_valid=0; release -> port0 granted first cycle.
// - RR fairness: 4 ports always valid, single-beat packets, i_ready=1 -> i_id sequence 0,1,2,3,0,... 1/cycle.
// - Lock: port1 sends 3-beat packet (last on beat 3) while port2 valid -> i_id=1,1,1 then 2; no interleave.
// - Backpressure: i_ready=0 for 5 cycles -> exactly 2 beats buffered, t_ready=0; head data stable;
//   i_ready=1 -> 2 buffered beats then stream resumes, no loss/duplication.
// - Random: random t_valid/i_ready 10k cycles vs scoreboard per port -> per-port order kept, packets contiguous.
// - Reset mid-packet: rst pulse while LOCKED on port3 -> i_valid=0 next cycle, next grant port0.

Source files
------------

// File: rtl/eb_pkg.sv
// eb_pkg: shared types and helpers for the elastic-buffer arbiter slice
//   arb_state_e : arbiter lock state (idle / locked on a packet)
//   clog2_min1  : $clog2 clamped to at least 1 for tag widths
package eb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/eb2.sv
// eb2: 2-entry registered elastic buffer, full throughput, no ready combinational path
//   clk, rst          : clock, asynchronous active-high reset
//   t_data/t_valid    : upstream beat in
//   t_ready           : registered, high while fewer than 2 entries will be held
//   i_data/i_valid    : head entry out, stable while stalled
//   i_ready           : downstream ready
module eb2 #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] t_data,
  input  logic              t_valid,
  output logic              t_ready,
  output logic [DWIDTH-1:0] i_data,
  output logic              i_valid,
  input  logic              i_ready
);
  logic [1:0]        cnt, cnt_nxt;
  logic [DWIDTH-1:0] e1;
  logic              push, pop;
  always_comb begin
    push    = t_valid & t_ready;
    pop     = i_valid & i_ready;
    i_valid = cnt != 2'd0;
    cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
  end
  // i_data is the head entry itself; e1 holds the second beat only while two are stored
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      t_ready <= 1'b0;
      i_data  <= '0;
      e1      <= '0;
    end else begin
      cnt     <= cnt_nxt;
      t_ready <= cnt_nxt != 2'd2;
      if ((cnt == 2'd0 && push) || (cnt == 2'd1 && push && pop) || (cnt == 2'd2 && pop))
        i_data <= (cnt == 2'd2) ? e1 : t_data;
      if (cnt == 2'd1 && push && !pop)
        e1 <= t_data;
    end
endmodule

// File: rtl/eb_rr_arb.sv
// eb_rr_arb: round-robin packet-locked arbiter feeding one registered elastic output
//   clk, rst                 : clock, asynchronous active-high reset
//   t_data/t_last/t_valid    : NUM_PORTS requester streams (port p data at [p*DWIDTH +: DWIDTH])
//   t_ready                  : one-hot (or zero) requester ready
//   i_data/i_last/i_id       : output beat and its source port
//   i_valid/i_ready          : output handshake
module eb_rr_arb
  import eb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int DWIDTH    = 32,
  localparam int IDW       = clog2_min1(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*DWIDTH-1:0] t_data,
  input  logic [NUM_PORTS-1:0]        t_last,
  input  logic [NUM_PORTS-1:0]        t_valid,
  output logic [NUM_PORTS-1:0]        t_ready,
  output logic [DWIDTH-1:0]           i_data,
  output logic                        i_last,
  output logic [IDW-1:0]              i_id,
  output logic                        i_valid,
  input  logic                        i_ready
);
  arb_state_e           state, state_nxt;
  logic [IDW-1:0]       ptr, lock_id, srch, idx, gid;
  logic                 found, gnt, rdy, push_v, acc, last;
  logic [DWIDTH-1:0]    data;
  logic [DWIDTH+IDW:0]  pay_out;
  // search ptr+1 .. ptr+NUM_PORTS over a doubled index range so wrap needs no modulo on ptr
  always_comb begin
    found = 1'b0;
    srch  = '0;
    idx   = '0;
    for (int i = 0; i < 2 * NUM_PORTS; i++) begin
      idx = IDW'(i % NUM_PORTS);
      if (!found && i > int'(ptr) && i <= int'(ptr) + NUM_PORTS && t_valid[idx]) begin
        found = 1'b1;
        srch  = idx;
      end
    end
  end
  always_comb begin
    gid       = (state == ARB_LOCKED) ? lock_id : srch;
    gnt       = (state == ARB_LOCKED) || found;
    t_ready   = (rdy && gnt) ? (NUM_PORTS'(1) << gid) : '0;
    push_v    = gnt & t_valid[gid];
    acc       = push_v & rdy;
    last      = t_last[gid];
    data      = t_data[gid*DWIDTH +: DWIDTH];
    state_nxt = acc ? (last ? ARB_IDLE : ARB_LOCKED) : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= ARB_IDLE;
      ptr     <= IDW'(NUM_PORTS - 1);
      lock_id <= '0;
    end else begin
      state <= state_nxt;
      if (acc && last)
        ptr <= gid;
      if (acc && !last && state == ARB_IDLE)
        lock_id <= gid;
    end
  eb2 #(.DWIDTH(DWIDTH + 1 + IDW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .t_data  ({last, gid, data}),
    .t_valid (push_v),
    .t_ready (rdy),
    .i_data  (pay_out),
    .i_valid (i_valid),
    .i_ready (i_ready)
  );
  assign {i_last, i_id, i_data} = pay_out;
endmodule

// File: tb/tb_eb_rr_arb.sv
// tb_eb_rr_arb: directed and randomized self-checking bench for eb_rr_arb
module tb_eb_rr_arb;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] t_data;
  logic [3:0]   t_last, t_valid, t_ready;
  logic [31:0]  i_data;
  logic         i_last, i_valid, i_ready;
  logic [1:0]   i_id;
  int passed = 0;
  int total  = 0;

  eb_rr_arb #(.NUM_PORTS(4), .DWIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .t_data  (t_data),
    .t_last  (t_last),
    .t_valid (t_valid),
    .t_ready (t_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .i_id    (i_id),
    .i_valid (i_valid),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst = 1'b1;
    t_valid = '0;
    t_last  = '0;
    t_data  = '0;
    i_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_port_data;
    for (int p = 0; p < 4; p++) t_data[p*32 +: 32] = 32'hD0 + 32'(p);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    t_valid = 4'hF;
    t_last  = 4'hF;
    i_ready = 1'b1;
    set_port_data();
    @(posedge clk); #1;
    total++;
    if (t_ready !== 4'b0000) $display("FAIL reset_t_ready: got %b need 0000", t_ready); else passed++;
    total++;
    if ({i_valid, i_last, i_id, i_data} !== 36'd0)
      $display("FAIL reset_out: got valid=%b last=%b id=%0d data=%h need all zero", i_valid, i_last, i_id, i_data);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (t_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b need 0001", t_ready); else passed++;
    t_valid = '0;
  endtask

  task automatic test_rr;
    do_reset();
    set_port_data();
    t_last  = 4'hF;
    t_valid = 4'hF;
    i_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      total++;
      if (!(i_valid === 1'b1 && i_id === 2'(k % 4) && i_data === 32'hD0 + 32'(k % 4)))
        $display("FAIL rr_seq[%0d]: got valid=%b id=%0d data=%h need valid=1 id=%0d data=%h",
                 k, i_valid, i_id, i_data, k % 4, 32'hD0 + 32'(k % 4));
      else passed++;
    end
  endtask

  task automatic test_lock;
    do_reset();
    t_data[1*32 +: 32] = 32'h11;
    t_data[2*32 +: 32] = 32'h22;
    t_last  = 4'b0100;
    t_valid = 4'b0110;
    i_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (t_ready !== 4'b0010) $display("FAIL lock_ready: got %b need 0010", t_ready); else passed++;
    total++;
    if ({i_valid, i_last, i_id, i_data} !== {1'b1, 1'b0, 2'd1, 32'h11})
      $display("FAIL lock_beat1: got v=%b l=%b id=%0d d=%h need v=1 l=0 id=1 d=11", i_valid, i_last, i_id, i_data);
    else passed++;
    t_data[1*32 +: 32] = 32'h12;
    @(posedge clk); #1;
    total++;
    if ({i_valid, i_last, i_id, i_data} !== {1'b1, 1'b0, 2'd1, 32'h12})
      $display("FAIL lock_beat2: got v=%b l=%b id=%0d d=%h need v=1 l=0 id=1 d=12", i_valid, i_last, i_id, i_data);
    else passed++;
    t_data[1*32 +: 32] = 32'h13;
    t_last[1] = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({i_valid, i_last, i_id, i_data} !== {1'b1, 1'b1, 2'd1, 32'h13})
      $display("FAIL lock_beat3: got v=%b l=%b id=%0d d=%h need v=1 l=1 id=1 d=13", i_valid, i_last, i_id, i_data);
    else passed++;
    t_valid[1] = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({i_valid, i_last, i_id, i_data} !== {1'b1, 1'b1, 2'd2, 32'h22})
      $display("FAIL lock_next: got v=%b l=%b id=%0d d=%h need v=1 l=1 id=2 d=22", i_valid, i_last, i_id, i_data);
    else passed++;
  endtask

  task automatic test_backpressure;
    do_reset();
    set_port_data();
    t_last  = 4'hF;
    t_valid = 4'b0011;
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i >= 1) begin
        total++;
        if (t_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b need 0000", i, t_ready); else passed++;
      end
      total++;
      if (!(i_valid === 1'b1 && i_id === 2'd0 && i_data === 32'hD0))
        $display("FAIL bp_head[%0d]: got v=%b id=%0d d=%h need v=1 id=0 d=d0", i, i_valid, i_id, i_data);
      else passed++;
    end
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (!(i_valid === 1'b1 && i_id === 2'((k + 1) % 2) && i_data === 32'hD0 + 32'((k + 1) % 2)))
        $display("FAIL bp_resume[%0d]: got v=%b id=%0d d=%h need v=1 id=%0d", k, i_valid, i_id, i_data, (k + 1) % 2);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int exp_id[6] = '{0, 1, 1, 2, 3, 0};
    do_reset();
    set_port_data();
    t_last  = 4'hF;
    t_valid = 4'hF;
    i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      total++;
      if (!(i_valid === 1'b1 && i_id === 2'(exp_id[k])))
        $display("FAIL b2b[%0d]: got v=%b id=%0d need v=1 id=%0d", k, i_valid, i_id, exp_id[k]);
      else passed++;
      i_ready = (k == 1) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_random;
    logic [34:0] q[$];
    logic [34:0] beat;
    logic [23:0] seq[4];
    logic [3:0]  acc;
    logic        out_locked;
    logic [1:0]  out_port;
    do_reset();
    out_locked = 1'b0;
    out_port   = '0;
    for (int p = 0; p < 4; p++) begin
      seq[p] = '0;
      t_data[p*32 +: 32] = {8'(p), 24'd0};
      t_last[p] = $urandom_range(0, 2) == 0;
    end
    t_valid = 4'($urandom);
    i_ready = 1'($urandom);
    for (int c = 0; c < 10100; c++) begin
      @(negedge clk);
      acc = t_valid & t_ready;
      total++;
      if (!$onehot0(t_ready)) $display("FAIL rnd_onehot[%0d]: got t_ready=%b need at most one bit", c, t_ready); else passed++;
      if (i_valid && i_ready) begin
        total++;
        if (q.size() == 0)
          $display("FAIL rnd_extra[%0d]: got id=%0d d=%h need no beat", c, i_id, i_data);
        else begin
          beat = q.pop_front();
          if ({i_last, i_id, i_data} !== beat || (out_locked && i_id !== out_port))
            $display("FAIL rnd_beat[%0d]: got l=%b id=%0d d=%h need l=%b id=%0d d=%h (locked=%b port=%0d)",
                     c, i_last, i_id, i_data, beat[34], beat[33:32], beat[31:0], out_locked, out_port);
          else passed++;
        end
        out_locked = !i_last;
        out_port   = i_id;
      end
      for (int p = 0; p < 4; p++)
        if (acc[p]) q.push_back({t_last[p], 2'(p), t_data[p*32 +: 32]});
      @(posedge clk); #1;
      for (int p = 0; p < 4; p++)
        if (acc[p]) begin
          seq[p] = seq[p] + 24'd1;
          t_data[p*32 +: 32] = {8'(p), seq[p]};
          t_last[p] = $urandom_range(0, 2) == 0;
        end
      t_valid = (c < 10000) ? ((t_valid & ~acc) | 4'($urandom)) : 4'b0000;
      i_ready = (c < 10000) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    total++;
    if (q.size() != 0) $display("FAIL rnd_drain: got %0d beats left need 0", q.size()); else passed++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_port_data();
    t_last  = 4'b0000;
    t_valid = 4'b1000;
    i_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (!(i_valid === 1'b1 && i_id === 2'd3 && t_ready === 4'b1000))
      $display("FAIL mid_lock: got v=%b id=%0d t_ready=%b need v=1 id=3 t_ready=1000", i_valid, i_id, t_ready);
    else passed++;
    t_valid = 4'b1001;
    #1;
    total++;
    if (t_ready !== 4'b1000) $display("FAIL mid_lock_hold: got %b need 1000", t_ready); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (i_valid !== 1'b0 || t_ready !== 4'b0000)
      $display("FAIL mid_flush: got v=%b t_ready=%b need v=0 t_ready=0000", i_valid, t_ready);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (t_ready !== 4'b0001 || i_valid !== 1'b0)
      $display("FAIL mid_regrant: got t_ready=%b v=%b need t_ready=0001 v=0", t_ready, i_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rr();
    test_lock();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
